// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-add per clock, LSB first, over two WIDTH-bit operands.
// Latency: start sampled at edge k -> done high for the cycle after edge k+WIDTH.
// Backpressure: none; start is honoured only in IDLE, otherwise dropped (not queued).
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ps;
    logic [WIDTH-1:0] ps_nxt;
    logic             carry;
    logic             carry_nxt;
    logic [CW-1:0]    count;
    logic             last_bit;
    logic             prop;
    logic             bit_sum;

    // The single full-adder cell shared by every bit position.
    assign prop      = sa[0] ^ sb[0];
    assign bit_sum   = prop ^ carry;
    assign carry_nxt = (sa[0] & sb[0]) | (prop & carry);
    assign ps_nxt    = {bit_sum, ps[WIDTH-1:1]};
    assign last_bit  = (count == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_bit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sa    <= '0;
            sb    <= '0;
            ps    <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= cin;
                        count <= '0;
                    end
                end
                S_RUN: begin
                    sa    <= {1'b0, sa[WIDTH-1:1]};
                    sb    <= {1'b0, sb[WIDTH-1:1]};
                    ps    <= ps_nxt;
                    carry <= carry_nxt;
                    count <= count + CW'(1);
                    // Result registers only move on completion, so partial sums stay hidden.
                    if (last_bit) begin
                        sum  <= ps_nxt;
                        cout <= carry_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller: sequences a single 1-bit full-add datapath, one bit per clock, LSB first, to add two WIDTH-bit operands.
- Owns the operand shift registers, carry flop, bit counter, result registers and the start/done handshake.
- Used where area matters more than latency; the only arithmetic is one sum/carry pair per cycle.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepted start edge
- b  input  WIDTH  operand B; captured on the accepted start edge
- cin  input  1  carry-in; captured on the accepted start edge
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result; holds the last completed sum
- cout  output  1  registered carry-out of the last completed add

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, with priority over all other inputs.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Shift registers, carry flop and counter are cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1. At that edge: load a into shift reg SA, load b into SB, carry<=cin, count<=0.
  - RUN: on each edge:
    - p=SA[0]^SB[0]; bit = p^carry; carry <= (SA[0]&SB[0]) | (p&carry).
    - SA and SB shift right by one. bit shifts into the MSB of partial-sum reg PS.
    - count increments.
  - RUN -> DONE on the edge that processes bit WIDTH-1 (count==WIDTH-1). At that same edge:
    - sum <= final PS value, including this last bit.
    - cout <= the carry produced by this last bit.
  - DONE -> IDLE unconditionally on the next edge.
- Outputs by state:
  - busy = 1 exactly while in RUN (registered-state decode).
  - done = 1 exactly while in DONE, which lasts one cycle.
- Latency: if start is sampled at edge k, done is high in the cycle between edge k+WIDTH and edge k+WIDTH+1. Minimum spacing between accepted starts is WIDTH+2 cycles.
- sum and cout update only on the RUN->DONE edge. They are stable from that point until the next completion or reset. Partial results are never visible on them.
- Input capture: a, b and cin are captured only at acceptance. Changes during RUN or DONE do not affect the result.
- start while busy, or in DONE: ignored, not queued. Software must re-issue it in IDLE.
- Arithmetic: modulo 2^WIDTH. {cout,sum} == a+b+cin exactly.
- Reset mid-operation: the operation is aborted and all outputs return to reset values on that edge. No done pulse is produced for it.
- Simultaneous reset and start: reset wins; the FSM stays in IDLE.

Test Plan:
- WIDTH=8; a=8'h3C, b=8'h5A, cin=0, start pulsed 1 cycle -> busy high for 8 cycles; done pulses 1 cycle with sum=8'h96, cout=0; done is high in the cycle following edge k+8.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1. Then a=8'h00, b=8'h00, cin=0 -> sum=8'h00, cout=0.
- Start an add of 8'h10+8'h20; in cycle 3 of RUN, pulse start with a=8'hFF, b=8'hFF, and also change a/b -> result is 8'h30, cout=0; no second done pulse follows.
- Reset asserted during RUN cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse appears afterward. A subsequent 8'h01+8'h01 add completes with sum=8'h02.
- Back-to-back adds: start held high continuously with 8'h7F+8'h01, cin=0 -> first done gives sum=8'h80, cout=0. Second start is accepted in IDLE two cycles after the first done edge, giving done pulses WIDTH+2=10 cycles apart.
- Random regression: 1000 random a, b, cin with random start gaps -> every done matches {cout,sum}=a+b+cin, and busy/done are never high together.
